// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master driver: command codes, FSM state
// encoding and the frame-width helper.
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SELECT     = 3'd1,
      ST_SHIFT_TX   = 3'd2,
      ST_TURNAROUND = 3'd3,
      ST_SHIFT_RX   = 3'd4,
      ST_GAP        = 3'd5
   } state_e;

   function automatic int frame_w(input int data_addr_size);
      return data_addr_size + 2;
   endfunction

endpackage

// File: rtl/spi_master_driver.sv
// SPI master: serialises {cmd, din} frames onto SS_n/MOSI and captures read bytes
// from MISO. Optional RD_ADDR-before-RD_DATA check enabled by SPI_MASTER_RD_SEQ_CHECK_EN.
module spi_master_driver #(
   parameter int DATA_ADDR_SIZE  = 8,
   parameter int MISO_TURNAROUND = 2,
   parameter int IDLE_GAP        = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [1:0]                cmd,
   input  logic [DATA_ADDR_SIZE-1:0] din,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_ADDR_SIZE-1:0] rd_data,
   output logic                      rd_valid,
   output logic                      err,
   output logic                      SS_n,
   output logic                      MOSI,
   input  logic                      MISO
);
   import spi_pkg::*;

   localparam int FRAME_W = frame_w(DATA_ADDR_SIZE);
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] TA_LAST  = CNT_W'(MISO_TURNAROUND - 1);
   localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(DATA_ADDR_SIZE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IDLE_GAP - 1);

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [FRAME_W-1:0]        tx_sr_q, tx_sr_d;
   logic [DATA_ADDR_SIZE-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_ADDR_SIZE-1:0] rd_data_q, rd_data_d;
   logic [1:0]                cmd_q, cmd_d;
   logic                      ss_n_q, ss_n_d;
   logic                      mosi_q, mosi_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      rd_valid_q, rd_valid_d;
   logic                      frame_end_s;

   assign frame_end_s = (state_q == ST_GAP) && (cnt_q == GAP_LAST);

   // Next-state, shift registers and pin values; pins are registered, so they
   // lag the state by one cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rd_data_d  = rd_data_q;
      cmd_d      = cmd_q;
      ss_n_d     = 1'b1;
      mosi_d     = 1'b0;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (start) begin
               state_d = ST_SELECT;
               cmd_d   = cmd;
               tx_sr_d = (cmd == CMD_RD_DATA) ? {cmd, {DATA_ADDR_SIZE{1'b0}}} : {cmd, din};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SELECT: begin
            ss_n_d  = 1'b0;
            mosi_d  = tx_sr_q[FRAME_W-1];
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_SHIFT_TX;
         end
         ST_SHIFT_TX: begin
            ss_n_d  = 1'b0;
            mosi_d  = tx_sr_q[FRAME_W-1];
            tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == TX_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = (cmd_q == CMD_RD_DATA) ? ST_TURNAROUND : ST_GAP;
            end else begin
               state_d = ST_SHIFT_TX;
            end
         end
         ST_TURNAROUND: begin
            ss_n_d = 1'b0;
            if (cnt_q == TA_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_SHIFT_RX;
            end else begin
               state_d = ST_TURNAROUND;
            end
         end
         ST_SHIFT_RX: begin
            ss_n_d  = 1'b0;
            rx_sr_d = {rx_sr_q[DATA_ADDR_SIZE-2:0], MISO};
            if (cnt_q == RX_LAST) begin
               rd_data_d = rx_sr_d;
               cnt_d     = {CNT_W{1'b0}};
               state_d   = ST_GAP;
            end else begin
               state_d = ST_SHIFT_RX;
            end
         end
         ST_GAP: begin
            if (frame_end_s) begin
               done_d     = 1'b1;
               rd_valid_d = (cmd_q == CMD_RD_DATA);
               cnt_d      = {CNT_W{1'b0}};
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         tx_sr_q    <= {FRAME_W{1'b0}};
         rx_sr_q    <= {DATA_ADDR_SIZE{1'b0}};
         rd_data_q  <= {DATA_ADDR_SIZE{1'b0}};
         cmd_q      <= 2'b00;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rd_data_q  <= rd_data_d;
         cmd_q      <= cmd_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef SPI_MASTER_RD_SEQ_CHECK_EN
   logic rd_addr_seen_q, rd_addr_seen_d;
   logic err_q, err_d;

   // Track RD_ADDR completion and flag RD_DATA accepted without one (sticky).
   always_comb begin
      rd_addr_seen_d = rd_addr_seen_q;
      err_d          = err_q;
      if ((state_q == ST_IDLE) && start && (cmd == CMD_RD_DATA) && !rd_addr_seen_q) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
      if (frame_end_s && (cmd_q == CMD_RD_ADDR)) begin
         rd_addr_seen_d = 1'b1;
      end else if (frame_end_s && (cmd_q == CMD_RD_DATA)) begin
         rd_addr_seen_d = 1'b0;
      end else begin
         rd_addr_seen_d = rd_addr_seen_q;
      end
   end

   // Sequence-check registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_addr_seen_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         rd_addr_seen_q <= rd_addr_seen_d;
         err_q          <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign SS_n     = ss_n_q;
   assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// Directed self-checking bench for spi_master_driver (default parameters).
module tb_spi_master_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] din = 8'h00;
   logic       busy, done, rd_valid, err, SS_n, MOSI;
   logic       MISO = 1'b0;
   logic [7:0] rd_data;

   int checks = 0;
   int fails  = 0;

`ifdef SPI_MASTER_RD_SEQ_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   spi_master_driver dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
      .err(err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Runs one frame for a fixed 40-cycle window, sampling on falling edges.
   // k is the index of the rising edge just passed; start is sampled at edge 0.
   task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] miso_b,
                            input int inject_at, input int rst_at,
                            output int ss_low, output logic [31:0] mosi_bits,
                            output int done_cnt, output int done_at,
                            output int rdv_cnt, output int rdv_at, output int busy_cnt);
      ss_low = 0; mosi_bits = 32'h0; done_cnt = 0; done_at = -1;
      rdv_cnt = 0; rdv_at = -1; busy_cnt = 0;
      @(negedge clk);
      start = 1'b1; cmd = c; din = d;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!SS_n) begin
            ss_low++;
            mosi_bits = {mosi_bits[30:0], MOSI};
         end
         if (done) begin
            done_cnt++;
            done_at = k;
         end
         if (rd_valid) begin
            rdv_cnt++;
            rdv_at = k;
         end
         if (busy) busy_cnt++;
         if (k == inject_at) begin
            start = 1'b1; cmd = 2'b11; din = 8'hFF;
         end else begin
            start = 1'b0;
         end
         if (k == rst_at) rst_n = 1'b0;
         if (k == rst_at + 1) rst_n = 1'b1;
         if (k >= 13 && k <= 20) MISO = miso_b[20-k];
         else MISO = 1'b0;
      end
   endtask

   int ss_low, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt;
   logic [31:0] mb;

   initial begin
      // Reset held with start pulsing: no SS_n activity.
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = (i % 2 == 0);
         cmd = 2'b00;
         chk("rst_ss_n", {31'h0, SS_n}, 32'h1);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ss_n", {31'h0, SS_n}, 32'h1);
         chk("idle_mosi", {31'h0, MOSI}, 32'h0);
         chk("idle_busy", {31'h0, busy}, 32'h0);
      end
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);

      // RD_DATA straight after reset: sequence error when the check is built in.
      run_frame(2'b11, 8'h00, 8'h5A, -1, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("rd0_ss_low", ss_low, 32'd21);
      chk("rd0_rd_data", {24'h0, rd_data}, 32'h5A);
      chk("rd0_err", {31'h0, err}, {31'h0, ERR_EN});

      run_frame(2'b00, 8'h3C, 8'h00, -1, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("wa_ss_low", ss_low, 32'd11);
      chk("wa_mosi", mb, 32'h03C);
      chk("wa_done_cnt", done_cnt, 32'd1);
      chk("wa_done_at", done_at, 32'd12);
      chk("wa_busy_cnt", busy_cnt, 32'd12);
      chk("wa_rdv_cnt", rdv_cnt, 32'd0);

      run_frame(2'b01, 8'hA5, 8'h00, -1, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("wd_mosi", mb, 32'h1A5);
      chk("wd_done_at", done_at, 32'd12);

      run_frame(2'b10, 8'h3C, 8'h00, -1, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("ra_mosi", mb, 32'h63C);
      chk("ra_rdv_cnt", rdv_cnt, 32'd0);
      chk("ra_rd_data_held", {24'h0, rd_data}, 32'h5A);

      run_frame(2'b11, 8'hFF, 8'hA5, -1, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("rd_ss_low", ss_low, 32'd21);
      chk("rd_mosi", mb, 32'h1C0000);
      chk("rd_rd_data", {24'h0, rd_data}, 32'hA5);
      chk("rd_done_at", done_at, 32'd22);
      chk("rd_rdv_at", rdv_at, 32'd22);
      chk("rd_rdv_cnt", rdv_cnt, 32'd1);
      chk("rd_busy_cnt", busy_cnt, 32'd22);
      chk("rd_err_sticky", {31'h0, err}, {31'h0, ERR_EN});

      // start during SHIFT_TX is ignored.
      run_frame(2'b01, 8'h11, 8'h00, 3, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("inj_ss_low", ss_low, 32'd11);
      chk("inj_mosi", mb, 32'h111);
      chk("inj_done_cnt", done_cnt, 32'd1);
      chk("inj_busy_cnt", busy_cnt, 32'd12);

      // Reset in the middle of SHIFT_TX abandons the frame.
      run_frame(2'b00, 8'hFF, 8'h00, -1, 5, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("mrst_ss_low", ss_low, 32'd5);
      chk("mrst_mosi", mb, 32'h03);
      chk("mrst_done_cnt", done_cnt, 32'd0);
      chk("mrst_busy_cnt", busy_cnt, 32'd6);
      chk("mrst_rd_data", {24'h0, rd_data}, 32'h0);
      chk("mrst_err", {31'h0, err}, 32'h0);

      run_frame(2'b00, 8'h01, 8'h00, -1, -1, ss_low, mb, done_cnt, done_at, rdv_cnt, rdv_at, busy_cnt);
      chk("post_ss_low", ss_low, 32'd11);
      chk("post_mosi", mb, 32'h001);
      chk("post_done_cnt", done_cnt, 32'd1);
      chk("post_done_at", done_at, 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
